// File: rtl/shift_unit_iter_if.sv
// Command/result bundle for the iterative shift unit: command handshake on
// the input side, result handshake with backpressure on the output side.
interface shift_unit_iter_if #(
  parameter int NBITS = 8,
  parameter int SHW   = $clog2(NBITS)
);
  logic             m_en;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic [NBITS-1:0] f_in;
  logic             msb_in;
  logic             lsb_in;
  logic [NBITS-1:0] f_out;
  logic             carry_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output m_en, in_valid, op, shamt, f_in, msb_in, lsb_in, out_ready,
    input  in_ready, f_out, carry_out, out_valid, busy
  );

  modport slave (
    input  m_en, in_valid, op, shamt, f_in, msb_in, lsb_in, out_ready,
    output in_ready, f_out, carry_out, out_valid, busy
  );
endinterface

// File: rtl/shift_unit_iter.sv
// Iterative shift/rotate unit. A persistent working register is loaded or
// shifted/rotated one bit position per clock; the result and the last bit
// shifted out are returned through a valid/ready handshake.
module shift_unit_iter #(
  parameter int NBITS = 8,
  parameter int SHW   = $clog2(NBITS)
) (
  input logic          clk,
  input logic          reset,
  shift_unit_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_LSL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_ASL  = 3'b111;

  state_t           state_q;
  logic [NBITS-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic [2:0]       op_q;
  logic             msb_q;
  logic             lsb_q;
  logic             carry_q;
  logic [NBITS-1:0] fOut_q;
  logic             carryOut_q;
  logic             outValid_q;

  logic [NBITS-1:0] work_d;
  logic             carry_d;
  logic             inReady;
  logic             busy;

  assign inReady       = bus.m_en && (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign bus.in_ready  = inReady;
  assign bus.busy      = busy;
  assign bus.f_out     = fOut_q;
  assign bus.carry_out = carryOut_q;
  assign bus.out_valid = outValid_q;

  // One-bit step of the captured operation; fill bits come from the values latched at accept.
  always_comb begin
    work_d  = work_q;
    carry_d = 1'b0;
    case (op_q)
      OP_LSR: begin work_d = {msb_q, work_q[NBITS-1:1]};         carry_d = work_q[0];       end
      OP_LSL: begin work_d = {work_q[NBITS-2:0], lsb_q};         carry_d = work_q[NBITS-1]; end
      OP_ROR: begin work_d = {work_q[0], work_q[NBITS-1:1]};     carry_d = work_q[0];       end
      OP_ROL: begin work_d = {work_q[NBITS-2:0], work_q[NBITS-1]}; carry_d = work_q[NBITS-1]; end
      OP_ASR: begin work_d = {work_q[NBITS-1], work_q[NBITS-1:1]}; carry_d = work_q[0];     end
      OP_ASL: begin work_d = {work_q[NBITS-2:0], 1'b0};          carry_d = work_q[NBITS-1]; end
      default: begin work_d = work_q;                            carry_d = 1'b0;            end
    endcase
  end

  // Control FSM: accept a command, step until the counter runs out, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      op_q       <= OP_HOLD;
      msb_q      <= 1'b0;
      lsb_q      <= 1'b0;
      carry_q    <= 1'b0;
      fOut_q     <= '0;
      carryOut_q <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && inReady) begin
            op_q    <= bus.op;
            msb_q   <= bus.msb_in;
            lsb_q   <= bus.lsb_in;
            carry_q <= 1'b0;
            if (bus.op == OP_LOAD) begin
              work_q <= bus.f_in;
            end
            if ((bus.op == OP_HOLD) || (bus.op == OP_LOAD)) begin
              cnt_q <= '0;
            end else begin
              cnt_q <= bus.shamt;
            end
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_q - SHW'(1);
          end else begin
            fOut_q     <= work_q;
            carryOut_q <= carry_q;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load data must be known whenever a load command is taken.
  assert property (@(posedge clk) disable iff (reset)
    (bus.in_valid && inReady && (bus.op == OP_LOAD)) |-> !$isunknown(bus.f_in));

  // The presented result must not move while the consumer stalls.
  assert property (@(posedge clk) disable iff (reset)
    (outValid_q && !bus.out_ready) |=> (outValid_q && $stable(fOut_q) && $stable(carryOut_q)));

  // Command acceptance is impossible while an operation is in flight.
  assert property (@(posedge clk) !(inReady && busy));

endmodule
